// File: rtl/shapool_sequencer.sv
// shapool_sequencer: walks the shapool core across a nonce range, one batch
// per core run, stopping on a match, range end, host abort or watchdog expiry.
module shapool_sequencer #(
  parameter int NONCE_WIDTH    = 32,
  parameter int POOL_SIZE_LOG2 = 1,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TIMEOUT_WIDTH  = 11
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   halt,
  input  logic [NONCE_WIDTH-1:0] nonce_start,
  input  logic [NONCE_WIDTH-1:0] nonce_end,
  output logic                   core_start,
  output logic [NONCE_WIDTH-1:0] core_nonce,
  input  logic                   core_done,
  input  logic                   core_success,
  output logic                   busy,
  output logic                   done,
  output logic [2:0]             status,
  output logic [NONCE_WIDTH-1:0] result_nonce,
  output logic [NONCE_WIDTH-1:0] batch_count
);

  // batch bases are aligned to the pool width; the step carries one extra
  // bit so the top-of-range carry-out can be seen directly
  localparam logic [NONCE_WIDTH-1:0] MASK    = {NONCE_WIDTH{1'b1}} << POOL_SIZE_LOG2;
  localparam logic [NONCE_WIDTH:0]   STEP    = {{NONCE_WIDTH{1'b0}}, 1'b1} << POOL_SIZE_LOG2;
  localparam logic [TIMEOUT_WIDTH-1:0] WD_LAST = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] ST_NONE      = 3'd0;
  localparam logic [2:0] ST_FOUND     = 3'd1;
  localparam logic [2:0] ST_EXHAUSTED = 3'd2;
  localparam logic [2:0] ST_ABORTED   = 3'd3;
  localparam logic [2:0] ST_TIMEOUT   = 3'd4;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t                   state, state_n;
  logic [NONCE_WIDTH-1:0]   nonce_n, count_n, result_n;
  logic [2:0]               status_n;
  logic [TIMEOUT_WIDTH-1:0] watchdog, wd_n;
  logic [NONCE_WIDTH:0]     nonce_inc;
  logic                     last_batch;

  assign nonce_inc  = {1'b0, core_nonce} + STEP;
  // the next base would either pass the inclusive end or wrap past zero
  assign last_batch = (core_nonce == (nonce_end & MASK)) || nonce_inc[NONCE_WIDTH];

  assign core_start = (state == S_ISSUE);
  assign busy       = (state == S_ISSUE) || (state == S_WAIT);
  assign done       = (state == S_DONE);

  // next-state and next register values
  always_comb begin
    state_n  = state;
    nonce_n  = core_nonce;
    count_n  = batch_count;
    status_n = status;
    result_n = result_nonce;
    wd_n     = watchdog;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_n  = S_ISSUE;
          nonce_n  = nonce_start & MASK;
          count_n  = '0;
          status_n = ST_NONE;
          result_n = '0;
        end
      end
      S_ISSUE: begin
        // the pulse goes out this cycle regardless, so it always counts
        count_n = batch_count + 1'b1;
        wd_n    = '0;
        if (halt) begin
          state_n  = S_DONE;
          status_n = ST_ABORTED;
        end else begin
          state_n = S_WAIT;
        end
      end
      S_WAIT: begin
        wd_n = watchdog + 1'b1;
        if (halt) begin
          state_n  = S_DONE;
          status_n = ST_ABORTED;
        end else if (core_done && core_success) begin
          state_n  = S_DONE;
          status_n = ST_FOUND;
          result_n = core_nonce;
        end else if (core_done && last_batch) begin
          state_n  = S_DONE;
          status_n = ST_EXHAUSTED;
        end else if (core_done) begin
          state_n = S_ISSUE;
          nonce_n = nonce_inc[NONCE_WIDTH-1:0];
        end else if (watchdog == WD_LAST) begin
          state_n  = S_DONE;
          status_n = ST_TIMEOUT;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // state and datapath registers; reset overrides any core handshake
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      core_nonce   <= '0;
      batch_count  <= '0;
      status       <= ST_NONE;
      result_nonce <= '0;
      watchdog     <= '0;
    end else begin
      state        <= state_n;
      core_nonce   <= nonce_n;
      batch_count  <= count_n;
      status       <= status_n;
      result_nonce <= result_n;
      watchdog     <= wd_n;
    end
  end

endmodule

// File: tb/tb_shapool_sequencer.sv
// tb_shapool_sequencer: directed plus randomized runs against a range-walk model.
module tb_shapool_sequencer;
  localparam int  W    = 32;
  localparam int  PL   = 1;
  localparam int  TO   = 1024;
  localparam longint STEP = 64'd1 << PL;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic         halt = 1'b0;
  logic [W-1:0] nonce_start = '0;
  logic [W-1:0] nonce_end = '0;
  logic         core_start;
  logic [W-1:0] core_nonce;
  logic         core_done = 1'b0;
  logic         core_success = 1'b0;
  logic         busy, done;
  logic [2:0]   status;
  logic [W-1:0] result_nonce, batch_count;

  int total = 0;
  int bad = 0;

  shapool_sequencer #(
    .NONCE_WIDTH(W), .POOL_SIZE_LOG2(PL), .TIMEOUT_CYCLES(TO), .TIMEOUT_WIDTH(11)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .halt(halt),
    .nonce_start(nonce_start), .nonce_end(nonce_end),
    .core_start(core_start), .core_nonce(core_nonce),
    .core_done(core_done), .core_success(core_success),
    .busy(busy), .done(done), .status(status),
    .result_nonce(result_nonce), .batch_count(batch_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_cs"}, 64'(core_start), 0);
    chk({tag, "_nonce"}, 64'(core_nonce), 0);
    chk({tag, "_busy"}, 64'(busy), 0);
    chk({tag, "_done"}, 64'(done), 0);
    chk({tag, "_status"}, 64'(status), 0);
    chk({tag, "_res"}, 64'(result_nonce), 0);
    chk({tag, "_bc"}, 64'(batch_count), 0);
  endtask

  // One launch. Per-batch core behaviour: batch hang_k never answers, batch
  // halt_k answers with success plus a simultaneous halt, batch issue_halt_k
  // gets halt during its launch cycle, batch succ_k answers with success.
  task automatic run_job(input logic [W-1:0] s, input logic [W-1:0] e, input int lat,
                         input int succ_k, input int halt_k, input int issue_halt_k,
                         input int hang_k);
    longint exp_q[$];
    longint n, end_m;
    int     exp_status;
    longint exp_res;
    int     k, cyc, resp, last_done, start_cyc, done_cyc;
    bit     fin;

    // reference: walk the aligned range and decide how the run ends
    n = longint'(s) & ~(STEP - 1);
    end_m = longint'(e) & ~(STEP - 1);
    exp_res = 0;
    exp_status = 0;
    for (int b = 0; b < 64 && exp_status == 0; b++) begin
      exp_q.push_back(n);
      if (b == issue_halt_k || b == halt_k) exp_status = 3;
      else if (b == hang_k) exp_status = 4;
      else if (b == succ_k) begin exp_status = 1; exp_res = n; end
      else if (n == end_m || n + STEP > 64'hFFFF_FFFF) exp_status = 2;
      else n = n + STEP;
    end

    nonce_start = s;
    nonce_end = e;
    start = 1'b1;
    tick();
    start = 1'b0;
    k = 0; cyc = 0; resp = -1; last_done = -1; start_cyc = 0; done_cyc = 0; fin = 0;
    while (!fin && cyc < 3000) begin
      core_done = 1'b0;
      core_success = 1'b0;
      halt = 1'b0;
      if (done) begin
        fin = 1;
        done_cyc = cyc;
      end else begin
        if (core_start) begin
          if (k < exp_q.size()) chk("nonce", 64'(core_nonce), exp_q[k]);
          else chk("extra_issue", 64'(k), 64'(exp_q.size()));
          chk("busy_issue", 64'(busy), 1);
          if (k == 0) begin
            chk("bc_launch", 64'(batch_count), 0);
            chk("st_launch", 64'(status), 0);
            chk("res_launch", 64'(result_nonce), 0);
          end else begin
            chk("gap", 64'(cyc - last_done), 1);
          end
          start_cyc = cyc;
          resp = (k == hang_k) ? -1 : cyc + lat;
          if (k == issue_halt_k) halt = 1'b1;
          k++;
        end
        if (cyc == resp) begin
          core_done = 1'b1;
          core_success = ((k - 1) == succ_k) || ((k - 1) == halt_k);
          halt = ((k - 1) == halt_k);
          last_done = cyc;
        end
        tick();
        cyc++;
      end
    end
    if (!fin) begin
      chk("run_bound", 0, 1);
    end else begin
      chk("status", 64'(status), 64'(exp_status));
      chk("result", 64'(result_nonce), 64'(exp_res));
      chk("batch_count", 64'(batch_count), 64'(exp_q.size()));
      chk("issued", 64'(k), 64'(exp_q.size()));
      chk("busy_done", 64'(busy), 0);
      if (exp_status == 4) chk("timeout_lat", 64'(done_cyc - start_cyc), 64'(TO + 1));
    end
    // DONE ignores halt and stray core handshakes
    halt = 1'b1;
    core_done = 1'b1;
    core_success = 1'b1;
    begin
      int extra = 0;
      for (int i = 0; i < 3; i++) begin
        tick();
        if (core_start) extra++;
      end
      chk("post_cs", 64'(extra), 0);
    end
    chk("post_done", 64'(done), 1);
    chk("post_status", 64'(status), 64'(exp_status));
    chk("post_res", 64'(result_nonce), 64'(exp_res));
    halt = 1'b0;
    core_done = 1'b0;
    core_success = 1'b0;
  endtask

  initial begin
    logic [W-1:0] s, e;
    int succ_k, halt_k, ihalt_k, hang_k;

    tick();
    tick();
    chk_all_zero("reset");
    reset = 1'b0;
    tick();
    chk_all_zero("idle");

    // directed: plain exhaust, success on 2nd, wrap at top, timeout, halt vs success
    run_job(32'h10, 32'h16, 5, -1, -1, -1, -1);
    run_job(32'h10, 32'h16, 5, 1, -1, -1, -1);
    run_job(32'hFFFF_FFFC, 32'h0, 3, -1, -1, -1, -1);
    run_job(32'h40, 32'h80, 2, -1, -1, -1, 0);
    run_job(32'h10, 32'h16, 4, -1, 0, -1, -1);
    run_job(32'h11, 32'h17, 1, -1, -1, -1, -1);
    run_job(32'h20, 32'h30, 2, -1, -1, 1, -1);

    // randomized ranges and core behaviour
    for (int j = 0; j < 40; j++) begin
      if ($urandom_range(0, 3) == 0) begin
        s = 32'hFFFF_FFF0 | W'($urandom_range(0, 15));
        e = W'($urandom_range(0, 15));
      end else begin
        s = $urandom & 32'h7FFF_FFFF;
        e = s + W'($urandom_range(0, 14));
      end
      succ_k  = ($urandom_range(0, 9) < 4) ? int'($urandom_range(0, 6)) : -1;
      halt_k  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 4)) : -1;
      ihalt_k = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 4)) : -1;
      hang_k  = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 3)) : -1;
      run_job(s, e, int'($urandom_range(1, 6)), succ_k, halt_k, ihalt_k, hang_k);
    end

    // reset mid-WAIT with a simultaneous successful core_done
    nonce_start = 32'h100;
    nonce_end = 32'h200;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("rst_run_cs", 64'(core_start), 1);
    tick();
    tick();
    reset = 1'b1;
    core_done = 1'b1;
    core_success = 1'b1;
    tick();
    reset = 1'b0;
    core_done = 1'b0;
    core_success = 1'b0;
    chk_all_zero("midrst");
    begin
      int extra = 0;
      for (int i = 0; i < 5; i++) begin
        tick();
        if (core_start || busy) extra++;
      end
      chk("midrst_idle", 64'(extra), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
